// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line bundle for uart_tx.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  Ready;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy, Ready
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy, Ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_BUF_EN to add a one-entry holding buffer for gapless back-to-back frames.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input logic      CLK,
    input logic      RST,
    uart_tx_if.slave bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] word_q, word_n;
    logic                  pen_q, pen_n;
    logic                  ptyp_q, ptyp_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;
    logic                  accept;
    logic                  par_bit;

`ifdef UART_TX_BUF_EN
    logic [DATA_WIDTH-1:0] buf_word_q, buf_word_n;
    logic                  buf_pen_q, buf_pen_n;
    logic                  buf_ptyp_q, buf_ptyp_n;
    logic                  buf_full_q, buf_full_n;

    assign bus.Ready = ~buf_full_q;
`else
    assign bus.Ready = ~busy_q;
`endif

    assign accept     = bus.Data_Valid & bus.Ready;
    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] w, input logic odd);
        return (^w) ^ odd;
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        word_n  = word_q;
        pen_n   = pen_q;
        ptyp_n  = ptyp_q;
`ifdef UART_TX_BUF_EN
        buf_word_n = buf_word_q;
        buf_pen_n  = buf_pen_q;
        buf_ptyp_n = buf_ptyp_q;
        buf_full_n = buf_full_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    word_n  = bus.P_DATA;
                    pen_n   = bus.PAR_EN;
                    ptyp_n  = bus.PAR_TYP;
                end
            end
            START: begin
                state_n = DATA;
                cnt_n   = '0;
            end
            DATA: begin
                if (cnt == CW'(DATA_WIDTH - 1)) begin
                    state_n = pen_q ? PARITY : STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PARITY: state_n = STOP;
            STOP: begin
                state_n = IDLE;
`ifdef UART_TX_BUF_EN
                // Chain straight into the buffered frame; Busy never drops.
                if (buf_full_q) begin
                    state_n    = START;
                    word_n     = buf_word_q;
                    pen_n      = buf_pen_q;
                    ptyp_n     = buf_ptyp_q;
                    buf_full_n = 1'b0;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
`ifdef UART_TX_BUF_EN
        if (accept && (state != IDLE)) begin
            buf_word_n = bus.P_DATA;
            buf_pen_n  = bus.PAR_EN;
            buf_ptyp_n = bus.PAR_TYP;
            buf_full_n = 1'b1;
        end
`endif
        // Line level is registered from the next state so TX_OUT is glitch-free.
        par_bit = parity_of(word_n, ptyp_n);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = word_n[cnt_n];
            PARITY:  tx_n = par_bit;
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
`ifdef UART_TX_BUF_EN
            buf_full_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tx_q   <= tx_n;
            busy_q <= busy_n;
`ifdef UART_TX_BUF_EN
            buf_full_q <= buf_full_n;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        word_q <= word_n;
        pen_q  <= pen_n;
        ptyp_q <= ptyp_n;
`ifdef UART_TX_BUF_EN
        buf_word_q <= buf_word_n;
        buf_pen_q  <= buf_pen_n;
        buf_ptyp_q <= buf_ptyp_n;
`endif
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, random frames against a bit-queue model, corner sequences.
module tb_uart_tx;
    localparam int DW = 8;
`ifdef UART_TX_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(DW)) bus();
    uart_tx #(.DATA_WIDTH(DW)) dut (.CLK(clk), .RST(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        int          exp_len;
        logic [63:0] exp_bits;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame as a list of line levels, one per cycle, index 0 = start bit.
    function automatic void model(input logic [7:0] d, input logic pen, input logic ptyp,
                                  output int len, output logic [63:0] bits);
        bit q[$];
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) q.push_back(d[i]);
        if (pen) q.push_back((($countones(d) % 2) == 1) ^ ptyp);
        q.push_back(1'b1);
        bits = '0;
        foreach (q[i]) bits[i] = q[i];
        len = q.size();
    endfunction

    // Called at a negedge while idle; returns at the negedge of the first idle cycle after Busy falls.
    task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input int inj, input logic [7:0] inj_d, input bit mutate,
                             output logic [63:0] bits, output int len);
        check("ready_before_accept", {63'd0, bus.Ready}, 64'd1);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        bits = '0;
        len  = 0;
        for (int c = 0; c < 40; c++) begin
            if (!bus.Busy) break;
            bits[c] = bus.TX_OUT;
            len++;
            if (c == inj) begin
                check("ready_during_frame", {63'd0, bus.Ready}, {63'd0, BUF});
                bus.P_DATA     = inj_d;
                bus.Data_Valid = 1'b1;
            end
            if (c == inj + 1) bus.Data_Valid = 1'b0;
            if (mutate && c == 3) begin
                bus.P_DATA  = 8'hFF;
                bus.PAR_TYP = ~bus.PAR_TYP;
            end
            @(negedge clk);
        end
        check("idle_after_frame_tx", {63'd0, bus.TX_OUT}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits, exp_bits, b2;
        int          len, exp_len, l2;
        bit          line_ok;

        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        rst_n          = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        check("tx_in_reset", {63'd0, bus.TX_OUT}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", {63'd0, bus.TX_OUT}, 64'd1);
        check("reset_busy", {63'd0, bus.Busy}, 64'd0);
        check("reset_ready", {63'd0, bus.Ready}, 64'd1);
        line_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) line_ok = 1'b0;
        end
        check("idle_line_high", {63'd0, line_ok}, 64'd1);

        // Vector table: fixed 0xA5 cases then random entries from the model
        vecs.push_back('{8'hA5, 1'b0, 1'b0, 10, 64'h34A});
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 11, 64'h54A});
        vecs.push_back('{8'hA5, 1'b1, 1'b1, 11, 64'h74A});
        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v.data = 8'($urandom);
            v.pen  = 1'($urandom);
            v.ptyp = 1'($urandom);
            model(v.data, v.pen, v.ptyp, v.exp_len, v.exp_bits);
            vecs.push_back(v);
        end
        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].pen, vecs[i].ptyp, -1, 8'h00, 1'b0, bits, len);
            check($sformatf("frame_bits[%0d]", i), bits, vecs[i].exp_bits);
            check($sformatf("busy_len[%0d]", i), 64'(len), 64'(vecs[i].exp_len));
        end

        // Inputs changed mid-frame must not affect the frame
        model(8'h3C, 1'b1, 1'b0, exp_len, exp_bits);
        run_frame(8'h3C, 1'b1, 1'b0, -1, 8'h00, 1'b1, bits, len);
        check("stable_bits", bits, exp_bits);
        check("stable_len", 64'(len), 64'(exp_len));

        // Overlapping Data_Valid during DATA
        model(8'hA5, 1'b0, 1'b0, exp_len, exp_bits);
        if (BUF) begin
            model(8'h11, 1'b0, 1'b0, l2, b2);
            exp_bits = exp_bits | (b2 << exp_len);
            exp_len  = exp_len + l2;
        end
        run_frame(8'hA5, 1'b0, 1'b0, 3, 8'h11, 1'b0, bits, len);
        check("overlap_bits", bits, exp_bits);
        check("overlap_len", 64'(len), 64'(exp_len));
        line_ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) line_ok = 1'b0;
        end
        check("overlap_no_extra_frame", {63'd0, line_ok}, 64'd1);

        // Reset during data bit 3
        bus.P_DATA     = 8'hA5;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_bit3", {62'd0, bus.TX_OUT, bus.Busy}, 64'b01);
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", {63'd0, bus.TX_OUT}, 64'd1);
        check("async_reset_busy", {63'd0, bus.Busy}, 64'd0);
        check("async_reset_ready", {63'd0, bus.Ready}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model(8'h5A, 1'b0, 1'b0, exp_len, exp_bits);
        run_frame(8'h5A, 1'b0, 1'b0, -1, 8'h00, 1'b0, bits, len);
        check("post_reset_bits", bits, exp_bits);
        check("post_reset_len", 64'(len), 64'(exp_len));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
